// File: rtl/multi_clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package multi_clock_divider_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

  // A limit of zero has no meaningful period, so it is promoted to one.
  function automatic cnt_t clamp_limit(input cnt_t v);
    return (v == '0) ? cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: counter, shadowed limit, divided clock and tick strobe.
// MULTI_CLOCK_DIVIDER_SYNC_EN adds a sync_req input that restarts the period.
module multi_clock_divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int DEFAULT_LIMIT = 1
) (
  input  logic             clk_signal_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             wr_stb,
  input  logic [CNT_W-1:0] wr_limit,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  input  logic             sync_req,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             limit_pending
);

  function automatic logic [CNT_W-1:0] sat_limit(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  localparam logic [CNT_W-1:0] RESET_LIMIT = sat_limit(CNT_W'(DEFAULT_LIMIT));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             restart;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  assign restart = !en || sync_req;
`else
  assign restart = !en;
`endif

  always_ff @(posedge clk_signal_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= CNT_W'(1);
      active_q    <= RESET_LIMIT;
      pending_q   <= RESET_LIMIT;
      pend_flag_q <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

  // Any limit update lands on a period boundary: terminal count, disable or sync.
  always_comb begin
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    clk_d       = clk_q;
    tick_d      = 1'b0;
    if (restart) begin
      cnt_d       = CNT_W'(1);
      clk_d       = 1'b0;
      active_d    = pending_q;
      pend_flag_d = 1'b0;
    end else if (cnt_q >= active_q) begin
      cnt_d       = CNT_W'(1);
      clk_d       = !clk_q;
      tick_d      = 1'b1;
      active_d    = pending_q;
      pend_flag_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A write arriving on the boundary cycle stays pending for the next period.
    if (wr_stb) begin
      pending_d   = sat_limit(wr_limit);
      pend_flag_d = 1'b1;
    end
  end

  assign clk_out       = clk_q;
  assign tick          = tick_q;
  assign limit_pending = pend_flag_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers sharing one source clock.
// MULTI_CLOCK_DIVIDER_SYNC_EN adds sync_req to phase-align all enabled channels.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int DEFAULT_LIMIT = 1,
  parameter int CH_IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_signal_in,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic                wr_en,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [CNT_W-1:0]    wr_limit,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  input  logic                sync_req,
`endif
  output logic [NUM_CH-1:0]   clk_signal_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   limit_pending
);

  logic [NUM_CH-1:0] wr_stb;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel indices never match, so such writes are dropped.
    assign wr_stb[i] = wr_en && (wr_ch == CH_IDX_W'(i));

    multi_clock_divider_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
    ) u_ch (
      .clk_signal_in (clk_signal_in),
      .reset_n       (reset_n),
      .en            (ch_enable[i]),
      .wr_stb        (wr_stb[i]),
      .wr_limit      (wr_limit),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      .sync_req      (sync_req),
`endif
      .clk_out       (clk_signal_out[i]),
      .tick          (tick[i]),
      .limit_pending (limit_pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed steps plus random traffic
// compared against an edge-index reference model.
module tb_multi_clock_divider;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int IW  = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] ch_enable;
  logic           wr_en;
  logic [IW-1:0]  wr_ch;
  logic [CW-1:0]  wr_limit;
  logic           sync_req;
  logic [NCH-1:0] clk_signal_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] limit_pending;

  int checks   = 0;
  int failures = 0;

  multi_clock_divider #(
    .NUM_CH        (NCH),
    .CNT_W         (CW),
    .DEFAULT_LIMIT (1)
  ) dut (
    .clk_signal_in  (clk),
    .reset_n        (reset_n),
    .ch_enable      (ch_enable),
    .wr_en          (wr_en),
    .wr_ch          (wr_ch),
    .wr_limit       (wr_limit),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    .sync_req       (sync_req),
`endif
    .clk_signal_out (clk_signal_out),
    .tick           (tick),
    .limit_pending  (limit_pending)
  );

  always #5 clk = ~clk;

  // Model: each channel remembers the edge index at which its current period began.
  int edge_n = 0;
  int m_act[NCH];
  int m_pend[NCH];
  int m_start[NCH];
  bit m_clk[NCH];
  bit m_tick[NCH];
  bit m_flag[NCH];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 1; m_pend[i] = 1; m_start[i] = edge_n;
      m_clk[i] = 0; m_tick[i] = 0; m_flag[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit srq;
    edge_n++;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    srq = sync_req;
`else
    srq = 1'b0;
`endif
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      m_tick[i] = 0;
      if (!ch_enable[i] || srq) begin
        m_clk[i] = 0; m_act[i] = m_pend[i]; m_flag[i] = 0; m_start[i] = edge_n;
      end else if (edge_n - m_start[i] >= m_act[i]) begin
        m_tick[i] = 1; m_clk[i] = !m_clk[i];
        m_act[i] = m_pend[i]; m_flag[i] = 0; m_start[i] = edge_n;
      end
      if (wr_en && int'(wr_ch) == i) begin
        m_pend[i] = (wr_limit == 0) ? 1 : int'(wr_limit);
        m_flag[i] = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] ec, et, ep;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_clk[i]; et[i] = m_tick[i]; ep[i] = m_flag[i];
    end
    chk("clk_signal_out", 32'(clk_signal_out), 32'(ec));
    chk("tick",           32'(tick),           32'(et));
    chk("limit_pending",  32'(limit_pending),  32'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input int lim);
    wr_en = 1'b1; wr_ch = IW'(ch); wr_limit = CW'(lim);
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ch_enable = '0; wr_en = 1'b0; wr_ch = '0; wr_limit = '0; sync_req = 1'b0;
    model_reset();
    #3;
    chk("reset_clk_out", 32'(clk_signal_out), 32'h0);
    chk("reset_tick",    32'(tick),           32'h0);
    chk("reset_pending", 32'(limit_pending),  32'h0);
    steps(2);

    // Default limit 1: every channel divides by two, tick every cycle.
    reset_n = 1'b1; ch_enable = '1;
    steps(4);
    chk("l1_tick", 32'(tick), 32'h1f);

    // Channel 0 to limit 5 while running at 1.
    write(0, 5);
    chk("ch0_pending", 32'(limit_pending[0]), 32'h1);
    steps(25);

    // Channel 1 to 8, then two rewrites before its terminal count.
    write(1, 8);
    steps(3);
    write(1, 2);
    write(1, 4);
    chk("ch1_pending", 32'(limit_pending[1]), 32'h1);
    steps(14);

    // Limit 0 is treated as 1; out-of-range channel indices are ignored.
    write(2, 0);
    steps(4);
    write(5, 3);
    write(7, 2);
    chk("oob_pending", 32'(limit_pending), 32'h0);
    steps(4);

    // Disable channel 3 mid-period with a write pending, then re-enable.
    write(3, 6);
    steps(5);
    write(3, 4);
    ch_enable[3] = 1'b0;
    step();
    chk("dis_clk3",     32'(clk_signal_out[3]), 32'h0);
    chk("dis_pending3", 32'(limit_pending[3]),  32'h0);
    steps(3);
    ch_enable[3] = 1'b1;
    steps(3);
    chk("reen_clk3_early", 32'(clk_signal_out[3]), 32'h0);
    step();
    chk("reen_clk3_first", 32'(clk_signal_out[3]), 32'h1);
    steps(10);

    // Maximum legal limit on channel 4.
    write(4, 255);
    steps(540);

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_clk_out", 32'(clk_signal_out), 32'h0);
    chk("async_tick",    32'(tick),           32'h0);
    chk("async_pending", 32'(limit_pending),  32'h0);
    steps(2);
    reset_n = 1'b1;
    steps(3);

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    // Misalign two limit-3 channels, then realign with a sync pulse.
    write(0, 3);
    write(1, 3);
    steps(4);
    ch_enable[1] = 1'b0;
    step();
    ch_enable[1] = 1'b1;
    steps(2);
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("sync_align", 32'(clk_signal_out[1]), 32'(clk_signal_out[0]));
    end
`endif

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      ch_enable = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '1;
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_ch     = IW'($urandom_range(0, 7));
      wr_limit  = CW'($urandom_range(0, 6));
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      sync_req  = ($urandom_range(0, 30) == 0);
`endif
      step();
    end
    wr_en = 1'b0; sync_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
